pb_field_serializer: RTL and testbench

- Sequential successor to the combinational varint/field-header encoder.
- Accepts one scalar protobuf field (id, type, 64-bit value) per valve-ready handshake and emits the wire-format encoding as a byte stream, one byte per cycle, with backpressure.
- Adds zigzag (sint), fixed32/fixed64, bool, and proper int32 sign extension, plus error detection and running byte/field counters.
- Sits between the CPU-facing register block and the message output buffer.

---
 rtl/pb_pkg.sv | 52 +++++
 rtl/pb_value_prep.sv | 44 ++++
 rtl/pb_field_serializer.sv | 154 +++++++++++++++
 tb/tb_pb_field_serializer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared protobuf field/wire type definitions and helpers
package pb_pkg;

  typedef enum logic [4:0] {
    FT_DOUBLE   = 5'd1,
    FT_FLOAT    = 5'd2,
    FT_INT64    = 5'd3,
    FT_UINT64   = 5'd4,
    FT_INT32    = 5'd5,
    FT_FIXED64  = 5'd6,
    FT_FIXED32  = 5'd7,
    FT_BOOL     = 5'd8,
    FT_STRING   = 5'd9,
    FT_GROUP    = 5'd10,
    FT_MESSAGE  = 5'd11,
    FT_BYTES    = 5'd12,
    FT_UINT32   = 5'd13,
    FT_ENUM     = 5'd14,
    FT_SFIXED32 = 5'd15,
    FT_SFIXED64 = 5'd16,
    FT_SINT32   = 5'd17,
    FT_SINT64   = 5'd18
  } field_type_e;

  typedef enum logic [2:0] {
    WT_VARINT = 3'd0,
    WT_I64    = 3'd1,
    WT_LEN    = 3'd2,
    WT_I32    = 3'd5
  } wire_type_e;

  // Key register width; {field_id, wire_type} never exceeds 32 bits.
  localparam int KEY_W = 32;

  function automatic wire_type_e wire_type_of(input field_type_e ft);
    case (ft)
      FT_DOUBLE, FT_FIXED64, FT_SFIXED64: return WT_I64;
      FT_FLOAT, FT_FIXED32, FT_SFIXED32:  return WT_I32;
      default:                            return WT_VARINT;
    endcase
  endfunction

  function automatic logic [63:0] zigzag64(input logic [63:0] v);
    return {v[62:0], 1'b0} ^ {64{v[63]}};
  endfunction

  // Length-delimited and group types are handled elsewhere, so they are rejected here.
  function automatic logic is_supported(input logic [4:0] t);
    return ((t >= FT_DOUBLE) && (t <= FT_BOOL)) || ((t >= FT_UINT32) && (t <= FT_SINT64));
  endfunction

endpackage

// File: rtl/pb_value_prep.sv
// rtl/pb_value_prep.sv - maps field type and raw value to the value the shifter emits
module pb_value_prep
  import pb_pkg::*;
(
  input  logic [4:0]  field_type,
  input  logic [63:0] value,
  output logic [2:0]  wire_type,
  output logic [63:0] prep_value,
  output logic        is_fixed,
  output logic [3:0]  fixed_len
);

  field_type_e ft;
  logic [31:0] zz32;

  assign ft   = field_type_e'(field_type);
  assign zz32 = {value[30:0], 1'b0} ^ {32{value[31]}};

  // Per-type value mapping; fixed types bypass varint and emit raw little-endian bytes.
  always_comb begin
    wire_type  = wire_type_of(ft);
    prep_value = value;
    is_fixed   = 1'b0;
    fixed_len  = 4'd0;
    case (ft)
      FT_INT32, FT_ENUM: prep_value = {{32{value[31]}}, value[31:0]};
      FT_UINT32:         prep_value = {32'b0, value[31:0]};
      FT_BOOL:           prep_value = {63'b0, value[0]};
      FT_SINT32:         prep_value = {32'b0, zz32};
      FT_SINT64:         prep_value = zigzag64(value);
      FT_FIXED32, FT_SFIXED32, FT_FLOAT: begin
        prep_value = {32'b0, value[31:0]};
        is_fixed   = 1'b1;
        fixed_len  = 4'd4;
      end
      FT_FIXED64, FT_SFIXED64, FT_DOUBLE: begin
        is_fixed  = 1'b1;
        fixed_len = 4'd8;
      end
      default: prep_value = value;
    endcase
  end

endmodule

// File: rtl/pb_field_serializer.sv
// rtl/pb_field_serializer.sv - serializes one scalar protobuf field into wire-format bytes
module pb_field_serializer
  import pb_pkg::*;
#(
  parameter int FID_W = 29,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FID_W-1:0] in_field_id,
  input  logic [4:0]       in_field_type,
  input  logic [63:0]      in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] byte_count,
  output logic [CNT_W-1:0] field_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_KEY  = 2'd1;
  localparam logic [1:0] ST_VAL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [63:0]      val_q, val_d;
  logic             fixed_q, fixed_d;
  logic [3:0]       fix_cnt_q, fix_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;
  logic [CNT_W-1:0] field_count_q, field_count_d;

  logic [2:0]  prep_wire;
  logic [63:0] prep_value;
  logic        prep_fixed;
  logic [3:0]  prep_len;
  logic        accept;
  logic        out_hs;

  pb_value_prep u_prep (
    .field_type (in_field_type),
    .value      (in_value),
    .wire_type  (prep_wire),
    .prep_value (prep_value),
    .is_fixed   (prep_fixed),
    .fixed_len  (prep_len)
  );

  assign in_ready    = (state_q == ST_IDLE) && !rst;
  assign accept      = in_valid && in_ready;
  assign out_hs      = out_valid && out_ready;
  assign err         = err_q;
  assign byte_count  = byte_count_q;
  assign field_count = field_count_q;

  // Output byte is formed directly from the current shift register, so it holds under backpressure.
  always_comb begin
    out_valid = (state_q != ST_IDLE);
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (state_q)
      ST_KEY: out_data = {|key_q[KEY_W-1:7], key_q[6:0]};
      ST_VAL: begin
        if (fixed_q) begin
          out_data = val_q[7:0];
          out_last = (fix_cnt_q == 4'd1);
        end else begin
          out_data = {|val_q[63:7], val_q[6:0]};
          out_last = ~|val_q[63:7];
        end
      end
      default: ;
    endcase
  end

  // Field FSM: accept/reject in IDLE, then shift out key varint and value bytes.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    val_d     = val_q;
    fixed_d   = fixed_q;
    fix_cnt_d = fix_cnt_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_supported(in_field_type) || (in_field_id == '0)) begin
            err_d = 1'b1;
          end else begin
            key_d     = KEY_W'({in_field_id, prep_wire});
            val_d     = prep_value;
            fixed_d   = prep_fixed;
            fix_cnt_d = prep_len;
            state_d   = ST_KEY;
          end
        end
      end
      ST_KEY: begin
        if (out_ready) begin
          key_d = key_q >> 7;
          if (key_q[KEY_W-1:7] == '0) state_d = ST_VAL;
        end
      end
      ST_VAL: begin
        if (out_ready) begin
          if (fixed_q) begin
            val_d     = val_q >> 8;
            fix_cnt_d = fix_cnt_q - 4'd1;
          end else begin
            val_d = val_q >> 7;
          end
          if (out_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters: a clear coinciding with a handshake keeps that handshake.
  always_comb begin
    byte_count_d  = cnt_clr ? CNT_W'(out_hs) : byte_count_q + CNT_W'(out_hs);
    field_count_d = cnt_clr ? CNT_W'(out_hs && out_last)
                            : field_count_q + CNT_W'(out_hs && out_last);
  end

  // State and datapath registers; reset discards any field in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      key_q         <= '0;
      val_q         <= '0;
      fixed_q       <= 1'b0;
      fix_cnt_q     <= 4'd0;
      err_q         <= 1'b0;
      byte_count_q  <= '0;
      field_count_q <= '0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      val_q         <= val_d;
      fixed_q       <= fixed_d;
      fix_cnt_q     <= fix_cnt_d;
      err_q         <= err_d;
      byte_count_q  <= byte_count_d;
      field_count_q <= field_count_d;
    end
  end

endmodule

// File: tb/tb_pb_field_serializer.sv
// tb/tb_pb_field_serializer.sv - directed self-checking bench for pb_field_serializer
module tb_pb_field_serializer;
  import pb_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [28:0] in_field_id;
  logic [4:0]  in_field_type;
  logic [63:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        err;
  logic        cnt_clr;
  logic [31:0] byte_count;
  logic [31:0] field_count;

  int n_checks;
  int n_fail;
  logic [7:0] exp_bytes[$];

  pb_field_serializer #(.FID_W(29), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_field_id   (in_field_id),
    .in_field_type (in_field_type),
    .in_value      (in_value),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .err           (err),
    .cnt_clr       (cnt_clr),
    .byte_count    (byte_count),
    .field_count   (field_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends one field and collects its bytes against exp_bytes. stall_idx/stall_len hold
  // out_ready low before that byte; clr_idx pulses cnt_clr on that byte's handshake;
  // abort_at returns once that many bytes have been taken.
  task automatic run_field(input string tag, input logic [28:0] id, input logic [4:0] ft,
                           input logic [63:0] v, input int stall_idx, input int stall_len,
                           input int clr_idx, input int abort_at);
    int  n;
    int  cyc;
    int  stalls;
    bit  done;
    n = 0; cyc = 0; stalls = 0; done = 0;
    @(negedge clk);
    expect_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_field_id = id; in_field_type = ft; in_value = v;
    @(negedge clk);
    in_valid = 1'b0; in_value = ~v; in_field_type = FT_STRING; in_field_id = '0;
    expect_eq({tag, "_latency"}, 64'(out_valid), 64'd1);
    expect_eq({tag, "_busy"}, 64'(in_ready), 64'd0);
    while (!done && cyc < 64) begin
      if (n == abort_at) begin
        done = 1;
      end else if (n == stall_idx && stalls < stall_len) begin
        out_ready = 1'b0;
        stalls++;
        expect_eq($sformatf("%s_hold%0d", tag, stalls), {55'd0, out_valid, out_data},
                  {55'd0, 1'b1, exp_bytes[n]});
        @(negedge clk);
      end else begin
        out_ready = 1'b1;
        cnt_clr = (n == clr_idx);
        if (out_valid) begin
          expect_eq($sformatf("%s_byte%0d", tag, n), 64'(out_data), 64'(exp_bytes[n]));
          expect_eq($sformatf("%s_last%0d", tag, n), 64'(out_last),
                    64'(n == exp_bytes.size() - 1));
          n++;
          if (n == exp_bytes.size()) done = 1;
        end
        @(negedge clk);
        cnt_clr = 1'b0;
      end
      cyc++;
    end
    if (abort_at < 0) begin
      expect_eq({tag, "_nbytes"}, 64'(n), 64'(exp_bytes.size()));
      expect_eq({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
      expect_eq({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    end
  endtask

  task automatic reject_field(input string tag, input logic [28:0] id, input logic [4:0] ft);
    @(negedge clk);
    in_valid = 1'b1; in_field_id = id; in_field_type = ft; in_value = 64'd7;
    @(negedge clk);
    in_valid = 1'b0;
    expect_eq({tag, "_err"}, 64'(err), 64'd1);
    expect_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
    expect_eq({tag, "_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    expect_eq({tag, "_err_done"}, 64'(err), 64'd0);
    expect_eq({tag, "_valid2"}, 64'(out_valid), 64'd0);
  endtask

  task automatic check_counts(input string tag, input int bytes, input int fields);
    expect_eq({tag, "_byte_count"}, 64'(byte_count), 64'(bytes));
    expect_eq({tag, "_field_count"}, 64'(field_count), 64'(fields));
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; in_field_id = '0; in_field_type = '0; in_value = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    expect_eq("rst_in_ready", 64'(in_ready), 64'd0);
    expect_eq("rst_out_valid", 64'(out_valid), 64'd0);
    expect_eq("rst_out_data", 64'(out_data), 64'd0);
    expect_eq("rst_out_last", 64'(out_last), 64'd0);
    expect_eq("rst_err", 64'(err), 64'd0);
    check_counts("rst", 0, 0);
    rst = 1'b0;

    exp_bytes = '{8'h08, 8'h96, 8'h01};
    run_field("int32_150", 29'd1, FT_INT32, 64'd150, -1, 0, -1, -1);
    check_counts("after_first", 3, 1);

    exp_bytes = '{8'h10, 8'h01};
    run_field("sint32_m1", 29'd2, FT_SINT32, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, -1, -1);

    exp_bytes = '{8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    run_field("int32_m1", 29'd1, FT_INT32, 64'h0000_0000_FFFF_FFFF, -1, 0, -1, -1);

    exp_bytes = '{8'h1D, 8'h78, 8'h56, 8'h34, 8'h12};
    run_field("fixed32", 29'd3, FT_FIXED32, 64'hDEAD_BEEF_1234_5678, -1, 0, -1, -1);

    exp_bytes = '{8'h80, 8'h01, 8'h00};
    run_field("uint64_0", 29'd16, FT_UINT64, 64'd0, -1, 0, -1, -1);
    check_counts("accum", 24, 5);

    exp_bytes = '{8'h08, 8'h03};
    run_field("sint64_m2", 29'd1, FT_SINT64, 64'hFFFF_FFFF_FFFF_FFFE, -1, 0, -1, -1);

    exp_bytes = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    run_field("double", 29'd1, FT_DOUBLE, 64'h0102_0304_0506_0708, -1, 0, -1, -1);

    exp_bytes = '{8'h08, 8'h96, 8'h01};
    run_field("stall", 29'd1, FT_INT32, 64'd150, 1, 3, 2, -1);
    check_counts("clr_on_hs", 1, 1);

    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    check_counts("clr_idle", 0, 0);

    reject_field("rej_string", 29'd5, FT_STRING);
    reject_field("rej_id0", 29'd0, FT_INT64);
    check_counts("after_reject", 0, 0);

    exp_bytes = '{8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    run_field("rst_mid", 29'd1, FT_INT32, 64'hFFFF_FFFF, -1, 0, -1, 2);
    rst = 1'b1;
    @(negedge clk);
    expect_eq("rst_mid_valid", 64'(out_valid), 64'd0);
    expect_eq("rst_mid_ready", 64'(in_ready), 64'd0);
    check_counts("rst_mid", 0, 0);
    rst = 1'b0;
    @(negedge clk);
    expect_eq("post_rst_ready", 64'(in_ready), 64'd1);
    expect_eq("post_rst_valid", 64'(out_valid), 64'd0);

    exp_bytes = '{8'h08, 8'h01};
    run_field("bool_1", 29'd1, FT_BOOL, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, -1, -1);
    check_counts("final", 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
